// File: rtl/torpedo_pkg.sv
// Shared types and constants for the torpedo launch controller and its slots.
package torpedo_pkg;

   localparam int TRIG_W      = 18;
   localparam int XY_FRACTION = 7;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TRIG     = 3'd1,
      LAUNCH   = 3'd2,
      COOLDOWN = 3'd3,
      WAIT_REL = 3'd4
   } sched_state_t;

endpackage

// File: rtl/frame_debounce.sv
// Frame-gated button debounce: the level rises only if the button stayed high
// for a whole frame; press is the registered rising edge of that level.
module frame_debounce (
   input  logic clk,
   input  logic resetN,
   input  logic vsync,
   input  logic btn,
   output logic deb,
   output logic press
);

   logic test;
   logic deb_d1;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         test   <= 1'b0;
         deb    <= 1'b0;
         deb_d1 <= 1'b0;
      end else begin
         deb_d1 <= deb;
         if (vsync) begin
            deb  <= test;
            test <= 1'b1;
         end else begin
            test <= test & btn;
         end
      end
   end

   assign press = deb & ~deb_d1;

endmodule

// File: rtl/torpedo_launch_sched.sv
// Central torpedo launch scheduler: debounced fire, trig ROM fetch, lowest free
// slot launch. Define TORPEDO_AUTOFIRE_EN for repeat fire while fire is held.
module torpedo_launch_sched
   import torpedo_pkg::*;
#(
   parameter int WIDTH           = 640,
   parameter int HEIGHT          = 480,
   parameter int TORPEDOS        = 4,
   parameter int ANGLES          = 360,
   parameter int TRIG_LAT        = 2,
   parameter int COOLDOWN_FRAMES = 8,
   localparam int X_W = $clog2(WIDTH),
   localparam int Y_W = $clog2(HEIGHT),
   localparam int A_W = $clog2(ANGLES)
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     vsync,
   input  logic                     fire,
   input  logic [A_W-1:0]           ship_angle,
   input  logic [X_W-1:0]           ship_x,
   input  logic [Y_W-1:0]           ship_y,
   input  logic [TORPEDOS-1:0]      slot_busy,
   output logic [A_W-1:0]           trig_addr,
   input  logic signed [TRIG_W-1:0] trig_sin,
   input  logic signed [TRIG_W-1:0] trig_cos,
   output logic [TORPEDOS-1:0]      launch,
   output logic signed [TRIG_W-1:0] launch_sin,
   output logic signed [TRIG_W-1:0] launch_cos,
   output logic [X_W-1:0]           launch_x,
   output logic [Y_W-1:0]           launch_y,
   output logic                     fire_denied,
   output logic                     fire_deb_out
);

   localparam int LAT_W = $clog2(TRIG_LAT + 1);
   localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

   sched_state_t        state;
   logic [LAT_W-1:0]    lat_cnt;
   logic [CD_W-1:0]     cd_cnt;
   logic                fire_deb;
   logic                press;
   logic                start;
   logic [TORPEDOS-1:0] sel;
   logic                any_free;

   frame_debounce u_fire_deb (
      .clk    (clk),
      .resetN (resetN),
      .vsync  (vsync),
      .btn    (fire),
      .deb    (fire_deb),
      .press  (press)
   );

   assign fire_deb_out = fire_deb;

`ifdef TORPEDO_AUTOFIRE_EN
   // A held button re-arms from IDLE without a fresh rising edge.
   assign start = press | fire_deb;
`else
   assign start = press;
`endif

   // Lowest-index free slot; slot_busy is used live so a slot freed this cycle counts.
   always_comb begin
      sel      = '0;
      any_free = 1'b0;
      for (int unsigned i = 0; i < TORPEDOS; i++) begin
         if (!slot_busy[i] && !any_free) begin
            sel[i]   = 1'b1;
            any_free = 1'b1;
         end
      end
   end

   assign launch      = (state == LAUNCH) ? sel : '0;
   assign fire_denied = (state == LAUNCH) && !any_free;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         cd_cnt     <= '0;
         trig_addr  <= '0;
         launch_x   <= '0;
         launch_y   <= '0;
         launch_sin <= '0;
         launch_cos <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  trig_addr <= ship_angle;
                  launch_x  <= ship_x;
                  launch_y  <= ship_y;
                  lat_cnt   <= LAT_W'(TRIG_LAT);
                  state     <= TRIG;
               end
            end
            TRIG: begin
               if (lat_cnt == '0) begin
                  launch_sin <= trig_sin;
                  launch_cos <= trig_cos;
                  state      <= LAUNCH;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            LAUNCH: begin
               if (any_free) begin
                  cd_cnt <= CD_W'(COOLDOWN_FRAMES);
                  state  <= COOLDOWN;
               end else begin
                  state <= WAIT_REL;
               end
            end
            COOLDOWN: begin
               if (cd_cnt == '0) begin
`ifdef TORPEDO_AUTOFIRE_EN
                  state <= fire_deb ? IDLE : WAIT_REL;
`else
                  state <= WAIT_REL;
`endif
               end else if (vsync) begin
                  cd_cnt <= cd_cnt - CD_W'(1);
               end
            end
            WAIT_REL: begin
               if (!fire_deb) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
